// File: rtl/aes_seq_pkg.sv
// Shared types for the iterative AES round sequencer.
//   AES_BLOCK_W : width of one AES state/key block
//   aes_block_t : one 128-bit AES block
//   seq_state_e : sequencer control states
package aes_seq_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller. Pops one plaintext block, applies the
// initial AddRoundKey, then loops the block NR times through an external round
// datapath (flagging the last round so mix_cols is bypassed) and pushes the
// ciphertext to the output FIFO. One block in flight at a time.
//
// Ports:
//   clock, reset             : single clock, synchronous active-high reset
//   in_state/_rd/_empty      : plaintext input FIFO (pop strobe out)
//   out_state/_wr/_full      : ciphertext output FIFO (push strobe out)
//   rnd_out/_wr/_full        : state pushed to round datapath
//   rnd_last                 : qualifies rnd_out, final round (no mix_cols)
//   rnd_in/_rd/_empty        : state returned from round datapath
//   rkey_idx / rkey          : key-schedule ROM index and same-cycle key
//   busy                     : sequencer not idle
//   stall_cnt                : only with AES_SEQ_STALL_CNT_EN, saturating
//                              count of cycles stalled on a FIFO flag
//
// Build option: define AES_SEQ_STALL_CNT_EN to add the stall_cnt output.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned NR      = 10,
  parameter int unsigned ROUND_W = $clog2(NR + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AES_BLOCK_W-1:0] in_state,
  output logic                   in_state_rd,
  input  logic                   in_state_empty,
  output logic [AES_BLOCK_W-1:0] out_state,
  output logic                   out_state_wr,
  input  logic                   out_state_full,
  output logic [AES_BLOCK_W-1:0] rnd_out,
  output logic                   rnd_out_wr,
  input  logic                   rnd_out_full,
  output logic                   rnd_last,
  input  logic [AES_BLOCK_W-1:0] rnd_in,
  output logic                   rnd_in_rd,
  input  logic                   rnd_in_empty,
  output logic [ROUND_W-1:0]     rkey_idx,
  input  logic [AES_BLOCK_W-1:0] rkey,
  output logic                   busy
`ifdef AES_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  seq_state_e             fsm_q;
  logic [AES_BLOCK_W-1:0] state_q;
  logic [ROUND_W-1:0]     round_q;
  logic                   last_round_c;

  assign last_round_c = (round_q == ROUND_W'(NR));

  // Both datapath-facing and FIFO-facing views of the block are the state register.
  assign rnd_out   = state_q;
  assign out_state = state_q;
  assign busy      = (fsm_q != IDLE);

  // Transfer strobes and key index; suppressed in the reset cycle so an
  // abandoned block never moves data.
  always_comb begin
    in_state_rd  = 1'b0;
    rnd_out_wr   = 1'b0;
    rnd_in_rd    = 1'b0;
    out_state_wr = 1'b0;
    rnd_last     = 1'b0;
    rkey_idx     = '0;
    if (!reset) begin
      unique case (fsm_q)
        IDLE: begin
          in_state_rd = !in_state_empty;
        end
        ISSUE: begin
          rkey_idx   = round_q;
          rnd_last   = last_round_c;
          rnd_out_wr = !rnd_out_full;
        end
        WAIT: begin
          rkey_idx  = round_q;
          rnd_in_rd = !rnd_in_empty;
        end
        DONE: begin
          rkey_idx     = round_q;
          out_state_wr = !out_state_full;
        end
        default: begin
          rkey_idx = '0;
        end
      endcase
    end
  end

  // Control FSM, round counter and initial AddRoundKey.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_state_rd) begin
            state_q <= in_state ^ rkey;
            round_q <= ROUND_W'(1);
            fsm_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (rnd_out_wr) fsm_q <= WAIT;
        end
        WAIT: begin
          if (rnd_in_rd) begin
            state_q <= rnd_in;
            if (last_round_c) begin
              fsm_q <= DONE;
            end else begin
              round_q <= round_q + ROUND_W'(1);
              fsm_q   <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_state_wr) fsm_q <= IDLE;
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_SEQ_STALL_CNT_EN
  logic stall_c;

  assign stall_c = ((fsm_q == ISSUE) && rnd_out_full)  ||
                   ((fsm_q == WAIT)  && rnd_in_empty)  ||
                   ((fsm_q == DONE)  && out_state_full);

  // Saturating stall-cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
